// File: rtl/decode_queue.sv
// Purpose: instruction queue feeding a single-issue decoder with load-use hazard bubbles.
// Latency: an instruction pushed at edge E issues on the decode outputs after edge E+1 (empty queue, no stall/hazard).
// Backpressure: if_ready = !full with no same-cycle bypass; stall_in freezes the decode outputs and the queue head.
module decode_queue #(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_valid,
  input  logic [0:31]   if_inst,
  output logic          if_ready,
  input  logic          stall_in,
  input  logic          flush,
  output logic          ID_valid,
  output logic [0:4]    ID_rD,
  output logic [0:4]    ID_rA,
  output logic [0:4]    ID_rB,
  output logic [0:2]    ID_ppp,
  output logic [0:1]    ID_WW,
  output logic [0:5]    ID_func,
  output logic [0:15]   ID_imm,
  output logic          ID_wrEn,
  output logic          ID_memEn,
  output logic          ID_memwrEn,
  output logic          ID_decode_ctrl_bez,
  output logic          ID_decode_ctrl_bnez,
  output logic          ID_illegal,
  output logic [CW-1:0] ID_count
);

  localparam int AW = $clog2(DEPTH);

  logic [0:31]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic          hazard;
  logic [0:31]   head;

  logic dec_wr, dec_mem, dec_memwr, dec_bez, dec_bnez, dec_legal;
  logic reads_a, reads_b, reads_d;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign if_ready = !full;
  assign ID_count = count;
  assign head     = mem[rd_ptr];

  // Decode the queue head: control bits plus which register fields it reads.
  always_comb begin
    dec_wr    = 1'b0;
    dec_mem   = 1'b0;
    dec_memwr = 1'b0;
    dec_bez   = 1'b0;
    dec_bnez  = 1'b0;
    dec_legal = 1'b1;
    reads_a   = 1'b0;
    reads_b   = 1'b0;
    reads_d   = 1'b0;
    case (head[0:5])
      6'b101010: begin dec_wr = 1'b1; reads_a = 1'b1; reads_b = 1'b1; end
      6'b100000: begin dec_wr = 1'b1; dec_mem = 1'b1; reads_a = 1'b1; end
      6'b100001: begin dec_mem = 1'b1; dec_memwr = 1'b1; reads_a = 1'b1; reads_d = 1'b1; end
      6'b100010: begin dec_bez = 1'b1; reads_d = 1'b1; end
      6'b100011: begin dec_bnez = 1'b1; reads_d = 1'b1; end
      6'b111100: dec_legal = 1'b1;
      default:   dec_legal = 1'b0;
    endcase
  end

  // A load on the outputs is identified by wrEn & memEn; r0 never creates a dependency.
  assign hazard = ID_valid && ID_wrEn && ID_memEn && (ID_rD != 5'd0) &&
                  ((reads_a && (head[11:15] == ID_rD)) ||
                   (reads_b && (head[16:20] == ID_rD)) ||
                   (reads_d && (head[6:10]  == ID_rD)));

  assign push = if_valid && !full && !flush;
  assign pop  = !flush && !stall_in && !empty && !hazard;

  // Instruction storage; contents beyond the live window are never read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= if_inst;
  end

  // Queue pointers and occupancy; flush and reset both empty the queue.
  always_ff @(posedge clk) begin
    if (!reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Decode output register: issue on pop, bubble otherwise, freeze under stall.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ID_valid            <= 1'b0;
      ID_rD               <= '0;
      ID_rA               <= '0;
      ID_rB               <= '0;
      ID_ppp              <= '0;
      ID_WW               <= '0;
      ID_func             <= '0;
      ID_imm              <= '0;
      ID_wrEn             <= 1'b0;
      ID_memEn            <= 1'b0;
      ID_memwrEn          <= 1'b0;
      ID_decode_ctrl_bez  <= 1'b0;
      ID_decode_ctrl_bnez <= 1'b0;
      ID_illegal          <= 1'b0;
    end else if (flush || (!stall_in && !pop)) begin
      ID_valid            <= 1'b0;
      ID_wrEn             <= 1'b0;
      ID_memEn            <= 1'b0;
      ID_memwrEn          <= 1'b0;
      ID_decode_ctrl_bez  <= 1'b0;
      ID_decode_ctrl_bnez <= 1'b0;
    end else if (pop) begin
      ID_valid            <= 1'b1;
      ID_rD               <= head[6:10];
      ID_rA               <= head[11:15];
      ID_rB               <= head[16:20];
      ID_ppp              <= head[21:23];
      ID_WW               <= head[24:25];
      ID_func             <= head[26:31];
      ID_imm              <= head[16:31];
      ID_wrEn             <= dec_wr;
      ID_memEn            <= dec_mem;
      ID_memwrEn          <= dec_memwr;
      ID_decode_ctrl_bez  <= dec_bez;
      ID_decode_ctrl_bnez <= dec_bnez;
      if (!dec_legal) ID_illegal <= 1'b1;
    end
  end

endmodule

// File: tb/tb_decode_queue.sv
// Purpose: randomized and directed checking of decode_queue against a queue-based reference model.
// Latency: one step() per clock; outputs compared 1 time unit after each rising edge.
// Backpressure: model tracks if_ready/full, stall hold and flush exactly as the outputs must show them.
module tb_decode_queue;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk;
  logic          reset;
  logic          if_valid;
  logic [0:31]   if_inst;
  logic          if_ready;
  logic          stall_in;
  logic          flush;
  logic          ID_valid;
  logic [0:4]    ID_rD, ID_rA, ID_rB;
  logic [0:2]    ID_ppp;
  logic [0:1]    ID_WW;
  logic [0:5]    ID_func;
  logic [0:15]   ID_imm;
  logic          ID_wrEn, ID_memEn, ID_memwrEn, ID_decode_ctrl_bez, ID_decode_ctrl_bnez;
  logic          ID_illegal;
  logic [CW-1:0] ID_count;

  int errors = 0;
  int checks = 0;

  decode_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .if_valid(if_valid), .if_inst(if_inst), .if_ready(if_ready),
    .stall_in(stall_in), .flush(flush), .ID_valid(ID_valid),
    .ID_rD(ID_rD), .ID_rA(ID_rA), .ID_rB(ID_rB), .ID_ppp(ID_ppp), .ID_WW(ID_WW),
    .ID_func(ID_func), .ID_imm(ID_imm), .ID_wrEn(ID_wrEn), .ID_memEn(ID_memEn),
    .ID_memwrEn(ID_memwrEn), .ID_decode_ctrl_bez(ID_decode_ctrl_bez),
    .ID_decode_ctrl_bnez(ID_decode_ctrl_bnez), .ID_illegal(ID_illegal), .ID_count(ID_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  logic [31:0] m_q[$];
  bit          m_valid, m_ill, m_last_load;
  logic [4:0]  m_ctrl; // {wrEn, memEn, memwrEn, bez, bnez}
  logic [31:0] m_fields; // last issued instruction word

  function automatic int fld(input logic [31:0] x, input int sh, input int mask);
    return int'((x >> sh) & 32'(mask));
  endfunction

  function automatic logic [4:0] ctrl_of(input int op);
    case (op)
      42: return 5'b10000;
      32: return 5'b11000;
      33: return 5'b01100;
      34: return 5'b00010;
      35: return 5'b00001;
      default: return 5'b00000;
    endcase
  endfunction

  function automatic bit legal_op(input int op);
    return op == 42 || op == 32 || op == 33 || op == 34 || op == 35 || op == 60;
  endfunction

  function automatic bit reads_reg(input logic [31:0] x, input int r);
    int op, rd, ra, rb;
    op = fld(x, 26, 63); rd = fld(x, 21, 31); ra = fld(x, 16, 31); rb = fld(x, 11, 31);
    case (op)
      42: return ra == r || rb == r;
      32: return ra == r;
      33: return ra == r || rd == r;
      34, 35: return rd == r;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [0:31] mk(input logic [5:0] op, input logic [4:0] rd, input logic [4:0] ra,
                                     input logic [4:0] rb, input logic [2:0] ppp, input logic [1:0] ww,
                                     input logic [5:0] fn);
    return {op, rd, ra, rb, ppp, ww, fn};
  endfunction

  task automatic model_update();
    bit do_push;
    logic [31:0] h;
    int op;
    if (!reset) begin
      m_q.delete();
      m_valid = 0; m_ill = 0; m_last_load = 0; m_ctrl = '0; m_fields = '0;
      return;
    end
    do_push = if_valid && (m_q.size() < DEPTH) && !flush;
    if (flush) begin
      m_q.delete();
      m_valid = 0; m_ctrl = '0; m_last_load = 0;
    end else begin
      if (!stall_in) begin
        if (m_q.size() > 0 &&
            !(m_valid && m_last_load && fld(m_fields, 21, 31) != 0 &&
              reads_reg(m_q[0], fld(m_fields, 21, 31)))) begin
          h = m_q.pop_front();
          op = fld(h, 26, 63);
          m_valid = 1; m_fields = h; m_ctrl = ctrl_of(op); m_last_load = (op == 32);
          if (!legal_op(op)) m_ill = 1;
        end else begin
          m_valid = 0; m_ctrl = '0; m_last_load = 0;
        end
      end
      if (do_push) m_q.push_back(if_inst);
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    chk("if_ready", 32'(if_ready), 32'(m_q.size() < DEPTH));
    chk("count",    32'(ID_count), 32'(m_q.size()));
    chk("valid",    32'(ID_valid), 32'(m_valid));
    chk("illegal",  32'(ID_illegal), 32'(m_ill));
    chk("ctrl",     32'({ID_wrEn, ID_memEn, ID_memwrEn, ID_decode_ctrl_bez, ID_decode_ctrl_bnez}), 32'(m_ctrl));
    chk("rD",   32'(ID_rD),   32'(fld(m_fields, 21, 31)));
    chk("rA",   32'(ID_rA),   32'(fld(m_fields, 16, 31)));
    chk("rB",   32'(ID_rB),   32'(fld(m_fields, 11, 31)));
    chk("ppp",  32'(ID_ppp),  32'(fld(m_fields, 8, 7)));
    chk("WW",   32'(ID_WW),   32'(fld(m_fields, 6, 3)));
    chk("func", 32'(ID_func), 32'(fld(m_fields, 0, 63)));
    chk("imm",  32'(ID_imm),  32'(fld(m_fields, 0, 65535)));
  endtask

  task automatic step(input logic v, input logic [0:31] inst, input logic st, input logic fl, input logic rs);
    if_valid = v; if_inst = inst; stall_in = st; flush = fl; reset = rs;
    @(posedge clk);
    model_update();
    #1;
    compare_all();
  endtask

  task automatic idle();
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
  endtask

  logic [0:31] r_inst, ld_inst;

  initial begin
    m_valid = 0; m_ill = 0; m_last_load = 0; m_ctrl = '0; m_fields = '0;
    if_valid = 0; if_inst = '0; stall_in = 0; flush = 0; reset = 0;

    // Reset state
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("rst_valid", 32'(ID_valid), 32'd0);
    chk("rst_ready", 32'(if_ready), 32'd1);
    chk("rst_count", 32'(ID_count), 32'd0);

    // First-instruction latency and field copies
    r_inst = mk(6'b101010, 5'd6, 5'd8, 5'd16, 3'b010, 2'b10, 6'b000110);
    step(1'b1, r_inst, 1'b0, 1'b0, 1'b1);
    chk("lat_not_yet", 32'(ID_valid), 32'd0);
    chk("lat_count", 32'(ID_count), 32'd1);
    idle();
    chk("r_valid", 32'(ID_valid), 32'd1);
    chk("r_wrEn", 32'(ID_wrEn), 32'd1);
    chk("r_rD", 32'(ID_rD), 32'd6);
    chk("r_rA", 32'(ID_rA), 32'd8);
    chk("r_rB", 32'(ID_rB), 32'd16);
    chk("r_imm", 32'(ID_imm), 32'h8286);

    // Load rD=3 followed by dependent R-type: exactly one bubble
    ld_inst = mk(6'b100000, 5'd3, 5'd1, 5'd0, 3'b0, 2'b0, 6'b0);
    step(1'b1, ld_inst, 1'b1, 1'b0, 1'b1);
    step(1'b1, mk(6'b101010, 5'd7, 5'd3, 5'd5, 3'b0, 2'b0, 6'b0), 1'b1, 1'b0, 1'b1);
    idle();
    chk("ld_issue", 32'(ID_memEn), 32'd1);
    idle();
    chk("haz_bubble", 32'(ID_valid), 32'd0);
    idle();
    chk("dep_issue", 32'(ID_valid), 32'd1);
    chk("dep_rA", 32'(ID_rA), 32'd3);

    // Load rD=0 never stalls; load rD=4 then store rD=4 does
    step(1'b1, mk(6'b100000, 5'd0, 5'd1, 5'd0, 3'b0, 2'b0, 6'b0), 1'b1, 1'b0, 1'b1);
    step(1'b1, mk(6'b101010, 5'd2, 5'd0, 5'd0, 3'b0, 2'b0, 6'b0), 1'b1, 1'b0, 1'b1);
    idle();
    idle();
    chk("r0_nobubble", 32'(ID_valid && ID_wrEn && !ID_memEn), 32'd1);
    step(1'b1, mk(6'b100000, 5'd4, 5'd1, 5'd0, 3'b0, 2'b0, 6'b0), 1'b1, 1'b0, 1'b1);
    step(1'b1, mk(6'b100001, 5'd4, 5'd0, 5'd0, 3'b0, 2'b0, 6'b0), 1'b1, 1'b0, 1'b1);
    idle();
    idle();
    chk("st_bubble", 32'(ID_valid), 32'd0);
    idle();
    chk("st_issue", 32'(ID_memwrEn), 32'd1);

    // Fill past DEPTH under stall, then drain in order
    for (int i = 1; i <= DEPTH + 1; i++) begin
      step(1'b1, mk(6'b101010, 5'(i), 5'd0, 5'd0, 3'b0, 2'b0, 6'b0), 1'b1, 1'b0, 1'b1);
      if (i == DEPTH) begin
        chk("full_count", 32'(ID_count), 32'(DEPTH));
        chk("full_ready", 32'(if_ready), 32'd0);
      end
    end
    chk("full_drop", 32'(ID_count), 32'(DEPTH));
    for (int i = 1; i <= DEPTH; i++) begin
      idle();
      chk("drain_rD", 32'(ID_rD), 32'(i));
    end
    idle();
    chk("drain_empty", 32'(ID_valid), 32'd0);

    // Undefined opcode: issues as nop and latches illegal
    step(1'b1, mk(6'b111111, 5'd1, 5'd1, 5'd1, 3'b0, 2'b0, 6'b0), 1'b0, 1'b0, 1'b1);
    idle();
    chk("ill_valid", 32'(ID_valid), 32'd1);
    chk("ill_ctrl", 32'({ID_wrEn, ID_memEn, ID_memwrEn, ID_decode_ctrl_bez, ID_decode_ctrl_bnez}), 32'd0);
    chk("ill_flag", 32'(ID_illegal), 32'd1);
    idle(); idle();
    chk("ill_sticky", 32'(ID_illegal), 32'd1);

    // Flush with three queued plus a concurrent push, under stall
    for (int i = 0; i < 3; i++) step(1'b1, r_inst, 1'b1, 1'b0, 1'b1);
    step(1'b1, r_inst, 1'b1, 1'b1, 1'b1);
    chk("flush_count", 32'(ID_count), 32'd0);
    chk("flush_valid", 32'(ID_valid), 32'd0);

    // Reset mid-drain
    for (int i = 0; i < 3; i++) step(1'b1, r_inst, 1'b1, 1'b0, 1'b1);
    idle();
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("mid_rst_ill", 32'(ID_illegal), 32'd0);
    chk("mid_rst_rD", 32'(ID_rD), 32'd0);
    chk("mid_rst_count", 32'(ID_count), 32'd0);
    idle();
    chk("post_rst_valid", 32'(ID_valid), 32'd0);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      logic [5:0] op;
      case ($urandom_range(0, 7))
        0: op = 6'b101010; 1: op = 6'b100000; 2: op = 6'b100001; 3: op = 6'b100010;
        4: op = 6'b100011; 5: op = 6'b111100; 6: op = 6'b100000;
        default: op = 6'($urandom_range(0, 63));
      endcase
      step(1'($urandom_range(0, 99) < 70),
           mk(op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
              3'($urandom), 2'($urandom), 6'($urandom)),
           1'($urandom_range(0, 99) < 30),
           1'($urandom_range(0, 99) < 5),
           1'($urandom_range(0, 99) != 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/decode_queue.md
DECODE_QUEUE -- requirements
Module: decode_queue

Interface
REQ-001 Parameter DEPTH, default 4, instruction buffer depth; power of two, 2..16.
REQ-002 Parameter CW, default $clog2(DEPTH)+1, occupancy count width.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-low reset, sampled on rising clk edge.
REQ-005 if_valid  input  1  fetch presents an instruction.
REQ-006 if_inst  input  [0:31]  instruction; MSB-first numbering, opcode [0:5], rD [6:10], rA [11:15], rB [16:20], ppp [21:23], WW [24:25], func [26:31], imm [16:31].
REQ-007 if_ready  output  1  queue can accept; equals !full, no same-cycle bypass.
REQ-008 stall_in  input  1  downstream stall; hold decode outputs.
REQ-009 flush  input  1  branch resolved taken; discard queued and decoded work.
REQ-010 ID_valid  output  1  decode outputs carry a real instruction.
REQ-011 ID_rD, ID_rA, ID_rB  output  [0:4] each  register fields.
REQ-012 ID_ppp [0:2], ID_WW [0:1], ID_func [0:5], ID_imm [0:15]  output  field copies.
REQ-013 ID_wrEn, ID_memEn, ID_memwrEn, ID_decode_ctrl_bez, ID_decode_ctrl_bnez  output  1 each  controls.
REQ-014 ID_illegal  output  1  sticky: an undefined opcode was decoded.
REQ-015 ID_count  output  [CW-1:0]  queue occupancy.

Function
REQ-016 Queue: circular FIFO of DEPTH entries; push when if_valid & if_ready & !flush.
REQ-017 Decode table (opcode -> wrEn/memEn/memwrEn/bez/bnez): 101010 R-type 1/0/0/0/0; 100000 load 1/1/0/0/0; 100001 store 0/1/1/0/0; 100010 bez 0/0/0/1/0; 100011 bnez 0/0/0/0/1; 111100 nop all 0.
REQ-018 Any other opcode decodes as nop and sets ID_illegal; ID_illegal clears only on reset.
REQ-019 Source registers: R-type rA, rB; load rA; store rA, rD; bez/bnez rD; nop none.
REQ-020 Load-use hazard when output holds ID_valid & load with ID_rD != 0 and queue head reads ID_rD.
REQ-021 Advance (stall_in=0, no flush): head nonempty and no hazard -> pop, register decode, ID_valid=1; otherwise ID_valid=0 (bubble), head kept.
REQ-022 stall_in=1: all ID_* outputs and queue head hold; pushes continue while not full.
REQ-023 Latency: instruction pushed at edge E appears on outputs after edge E+1 when queue empty and no stall/hazard.
REQ-024 Hazard bubble is exactly one cycle; dependent instruction issues the following cycle.
REQ-025 flush=1: next edge empties queue, ID_valid=0, ID_count=0; push in same cycle is dropped; flush overrides stall_in.
REQ-026 Simultaneous push and pop when not full: ID_count unchanged; pointers wrap modulo DEPTH.
REQ-027 Full: if_ready=0, if_valid ignored; empty: pop suppressed, bubble issued.
REQ-028 Field outputs (rD..imm) update only on issue; on bubble they hold last values, controls forced 0.

Reset
REQ-029 reset=0 at edge: pointers 0, ID_count=0, ID_valid=0, all controls 0, ID_illegal=0, fields 0, if_ready=1 next cycle.
REQ-030 Reset mid-operation discards queued instructions; no partial issue after reset.

Verification
REQ-031 Push 101010/rD=6/rA=8/rB=16/ppp=010/WW=10/func=000110 into empty queue -> one edge later ID_valid=1, wrEn=1, rD=6, rA=8, rB=16.
REQ-032 Load rD=3 then R-type with rA=3 back-to-back -> load issues, one bubble (ID_valid=0), R-type next cycle.
REQ-033 Load rD=0 then R-type rA=0 -> no bubble; load rD=4 then store rD=4 -> bubble.
REQ-034 Push DEPTH+1 instructions with stall_in=1 -> if_ready=0 at ID_count=DEPTH, extra dropped; release stall -> in-order drain.
REQ-035 Opcode 111111 -> ID_valid=1, all controls 0, ID_illegal=1 held until reset.
REQ-036 flush with 3 queued plus simultaneous push -> next cycle ID_count=0, ID_valid=0; reset=0 mid-drain -> all outputs at reset values.
